// File: rtl/i2c_pkg.sv
// Shared definitions for the register-file serial slave: FSM states and line levels.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RW,
        ACK,
        WDATA,
        RDATA,
        FACK,
        SKIP
    } state_t;

    // Level driven by the slave in an acknowledge slot.
    localparam logic ACK_LVL  = 1'b1;
    // Level of RX between frames; a start bit is the opposite level.
    localparam logic IDLE_LVL = 1'b1;
    // R/W bit value that requests a read; the other value is a write.
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/sclk_edge_sync.sv
// Brings SCLK and RX into the CLK domain and turns SCLK transitions into one-cycle
// rise/fall pulses. Pulses appear 2 CLK edges after the pin edge and are consumed
// by the downstream logic on the 3rd edge; RX has the same latency as SCLK.
module sclk_edge_sync
    import i2c_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic sclk_i,
    input  logic rx_i,
    output logic rise_o,
    output logic fall_o,
    output logic rx_o
);

    logic [2:0] sclk_q;
    logic [1:0] rx_q;

    // Two synchroniser stages per line plus one history stage on SCLK for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_q <= '0;
            rx_q   <= {2{IDLE_LVL}};
        end else begin
            sclk_q <= {sclk_q[1:0], sclk_i};
            rx_q   <= {rx_q[0], rx_i};
        end
    end

    assign rise_o = sclk_q[1] & ~sclk_q[2];
    assign fall_o = ~sclk_q[1] & sclk_q[2];
    assign rx_o   = rx_q[1];

endmodule

// File: rtl/i2c_slave_regfile.sv
// Serial bus slave with a DEPTH-entry register file selected by the address LSBs,
// write/read frames with ACK slots, a stall timeout and a host preload port.
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter int                        ADDR_W   = 8,
    parameter int                        DATA_W   = 8,
    parameter int                        IDX_W    = 2,
    parameter logic [ADDR_W-IDX_W-1:0]   DEV_ADDR = 6'h06,
    parameter int                        TO_CYC   = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SCLK,
    input  logic              RX,
    output logic              OUT,
    output logic              OUT_EN,
    output logic              BUSY,
    output logic              WR_STB,
    output logic [IDX_W-1:0]  WR_IDX,
    input  logic              LD_EN,
    input  logic [IDX_W-1:0]  LD_IDX,
    input  logic [DATA_W-1:0] LD_DATA
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam int CNT_W = $clog2(ADDR_W + DATA_W + 3);
    localparam int TO_W  = $clog2(TO_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] SKIP_LEN  = CNT_W'(DATA_W + 2);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYC - 1);

    logic rise, fall, rx_s;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [IDX_W-1:0]    idx_q;
    logic                rw_q;
    logic                out_q;
    logic                oe_q;
    logic                stb_q;
    logic [IDX_W-1:0]    wr_idx_q;
    logic [TO_W-1:0]     to_q;
    logic [TO_W-1:0]     to_d;
    logic                to_expire;
    logic [DATA_W-1:0]   regs_q [DEPTH];

    sclk_edge_sync u_sync (
        .clk_i  (CLK),
        .rst_i  (RST),
        .sclk_i (SCLK),
        .rx_i   (RX),
        .rise_o (rise),
        .fall_o (fall),
        .rx_o   (rx_s)
    );

    // Stall timer: restarts on any SCLK edge, runs only while a frame is open.
    always_comb begin
        to_d      = to_q;
        to_expire = 1'b0;
        if (rise || fall) begin
            to_d = '0;
        end else if (state_q != IDLE) begin
            if (to_q == TO_LAST) begin
                to_expire = 1'b1;
                to_d      = '0;
            end else begin
                to_d = to_q + TO_W'(1);
            end
        end
    end

    // Frame FSM with registered outputs and the register file; preload is applied last so it wins.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            idx_q    <= '0;
            rw_q     <= 1'b0;
            out_q    <= 1'b0;
            oe_q     <= 1'b0;
            stb_q    <= 1'b0;
            wr_idx_q <= '0;
            to_q     <= '0;
            regs_q   <= '{default: '0};
        end else begin
            stb_q <= 1'b0;
            to_q  <= to_d;
            if (to_expire) begin
                // An abandoned frame never reaches the commit point, so a partial write is dropped.
                state_q <= IDLE;
                out_q   <= 1'b0;
                oe_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        out_q <= 1'b0;
                        oe_q  <= 1'b0;
                        if (rise && rx_s == ~IDLE_LVL) begin
                            state_q <= ADDR;
                            cnt_q   <= '0;
                        end
                    end
                    ADDR: begin
                        if (rise) begin
                            addr_q <= {addr_q[ADDR_W-2:0], rx_s};
                            if (cnt_q == ADDR_LAST) begin
                                state_q <= RW;
                            end else begin
                                cnt_q <= cnt_q + CNT_ONE;
                            end
                        end
                    end
                    RW: begin
                        if (rise) begin
                            rw_q <= rx_s;
                            if (addr_q[ADDR_W-1:IDX_W] == DEV_ADDR) begin
                                idx_q   <= addr_q[IDX_W-1:0];
                                state_q <= ACK;
                            end else begin
                                cnt_q   <= SKIP_LEN;
                                state_q <= SKIP;
                            end
                        end
                    end
                    ACK: begin
                        if (fall) begin
                            oe_q  <= 1'b1;
                            out_q <= ACK_LVL;
                        end else if (rise) begin
                            cnt_q <= '0;
                            if (rw_q == RW_READ) begin
                                data_q  <= regs_q[idx_q];
                                state_q <= RDATA;
                            end else begin
                                state_q <= WDATA;
                            end
                        end
                    end
                    WDATA: begin
                        if (fall) begin
                            oe_q  <= 1'b0;
                            out_q <= 1'b0;
                        end else if (rise) begin
                            data_q <= {data_q[DATA_W-2:0], rx_s};
                            if (cnt_q == DATA_LAST) begin
                                regs_q[idx_q] <= {data_q[DATA_W-2:0], rx_s};
                                stb_q         <= 1'b1;
                                wr_idx_q      <= idx_q;
                                state_q       <= FACK;
                            end else begin
                                cnt_q <= cnt_q + CNT_ONE;
                            end
                        end
                    end
                    RDATA: begin
                        if (fall) begin
                            oe_q   <= 1'b1;
                            out_q  <= data_q[DATA_W-1];
                            data_q <= {data_q[DATA_W-2:0], 1'b0};
                        end else if (rise) begin
                            if (cnt_q == DATA_LAST) begin
                                state_q <= FACK;
                            end else begin
                                cnt_q <= cnt_q + CNT_ONE;
                            end
                        end
                    end
                    FACK: begin
                        if (fall) begin
                            if (rw_q == RW_READ) begin
                                oe_q  <= 1'b0;
                                out_q <= 1'b0;
                            end else begin
                                oe_q  <= 1'b1;
                                out_q <= ACK_LVL;
                            end
                        end else if (rise) begin
                            state_q <= IDLE;
                            oe_q    <= 1'b0;
                            out_q   <= 1'b0;
                        end
                    end
                    SKIP: begin
                        if (rise) begin
                            cnt_q <= cnt_q - CNT_ONE;
                            if (cnt_q == CNT_ONE) begin
                                state_q <= IDLE;
                                oe_q    <= 1'b0;
                                out_q   <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        oe_q    <= 1'b0;
                        out_q   <= 1'b0;
                    end
                endcase
            end
            if (LD_EN) begin
                regs_q[LD_IDX] <= LD_DATA;
            end
        end
    end

    assign OUT    = out_q;
    assign OUT_EN = oe_q;
    assign BUSY   = (state_q != IDLE);
    assign WR_STB = stb_q;
    assign WR_IDX = wr_idx_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Self-checking bench: a bus master drives frames, a register-array model predicts
// ACKs, read data, write strobes and register contents from the frame rules.
module tb_i2c_slave_regfile;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int IDX_W  = 2;
    localparam int TO_CYC = 1024;
    localparam int H      = 6;     // SCLK half period in CLK cycles

    logic CLK = 1'b0;
    logic RST, SCLK, RX, OUT, OUT_EN, BUSY, WR_STB, LD_EN;
    logic [IDX_W-1:0]  WR_IDX, LD_IDX;
    logic [DATA_W-1:0] LD_DATA;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] model [4];
    int                stb_cnt = 0;
    logic [IDX_W-1:0]  stb_idx = '0;
    int                oe_viol = 0;

    logic              s_ack_out, s_ack_oe, s_fack_out, s_fack_oe, s_any_oe, s_busy_pre;
    logic [DATA_W-1:0] s_rdata;

    i2c_slave_regfile #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W),
        .DEV_ADDR (6'h06),
        .TO_CYC   (TO_CYC)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SCLK    (SCLK),
        .RX      (RX),
        .OUT     (OUT),
        .OUT_EN  (OUT_EN),
        .BUSY    (BUSY),
        .WR_STB  (WR_STB),
        .WR_IDX  (WR_IDX),
        .LD_EN   (LD_EN),
        .LD_IDX  (LD_IDX),
        .LD_DATA (LD_DATA)
    );

    always #5 CLK = ~CLK;

    // Strobe counter and wired-OR safety monitor, sampled away from the active edge.
    always @(negedge CLK) begin
        if (WR_STB) begin
            stb_cnt = stb_cnt + 1;
            stb_idx = WR_IDX;
        end
        if (OUT && !OUT_EN) oe_viol = oe_viol + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic load(input int idx, input logic [DATA_W-1:0] d);
        LD_IDX  = IDX_W'(idx);
        LD_DATA = d;
        LD_EN   = 1'b1;
        tick(1);
        LD_EN   = 1'b0;
        model[idx] = d;
    endtask

    // One SCLK period: RX set while low, OUT sampled just before the rise.
    task automatic slot(input logic b, output logic so, output logic soe, output logic sb);
        RX = b;
        tick(H);
        so  = OUT;
        soe = OUT_EN;
        sb  = BUSY;
        SCLK = 1'b1;
        tick(H);
        SCLK = 1'b0;
    endtask

    task automatic frame(input logic [ADDR_W-1:0] addr, input logic rw, input logic [DATA_W-1:0] wd,
                         input int n_data, input int abort_at, input bit collide);
        logic so, soe, sb;
        s_any_oe = 1'b0;
        slot(1'b0, so, soe, sb);
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            slot(addr[i], so, soe, sb);
            s_any_oe |= soe;
        end
        slot(rw, so, soe, sb);
        s_any_oe |= soe;
        slot(1'b1, s_ack_out, s_ack_oe, sb);
        s_any_oe |= s_ack_oe;
        for (int i = DATA_W - 1; i >= DATA_W - n_data; i--) begin
            RX = rw ? 1'b1 : wd[i];
            tick(H);
            s_rdata[i] = OUT;
            s_any_oe |= OUT_EN;
            if (abort_at == DATA_W - 1 - i) begin
                chk("abort_oe_before", 32'(OUT_EN), 1);
                RST = 1'b1;
                tick(1);
                chk("abort_out", 32'(OUT), 0);
                chk("abort_oe", 32'(OUT_EN), 0);
                chk("abort_busy", 32'(BUSY), 0);
                RST = 1'b0;
                return;
            end
            SCLK = 1'b1;
            if (collide && i == 0) begin
                // The commit lands on the 3rd CLK edge after the pin edge; LD_EN is sampled there too.
                tick(2);
                LD_EN = 1'b1;
                tick(1);
                LD_EN = 1'b0;
                tick(H - 3);
            end else begin
                tick(H);
            end
            SCLK = 1'b0;
        end
        if (n_data < DATA_W) return;
        slot(1'b0, s_fack_out, s_fack_oe, s_busy_pre);
        s_any_oe |= s_fack_oe;
        tick(4);
    endtask

    // Full frame checked against the model.
    task automatic run_frame(input logic [ADDR_W-1:0] addr, input logic rw, input logic [DATA_W-1:0] wd);
        int stb0;
        int idx;
        bit match;
        stb0  = stb_cnt;
        idx   = int'(addr) % 4;
        match = (int'(addr) >= 'h18) && (int'(addr) <= 'h1B);
        frame(addr, rw, wd, DATA_W, -1, 1'b0);
        if (match) begin
            chk("ack_out", 32'(s_ack_out), 1);
            chk("ack_oe", 32'(s_ack_oe), 1);
            if (rw) begin
                chk("rdata", 32'(s_rdata), 32'(model[idx]));
                chk("rd_fack_oe", 32'(s_fack_oe), 0);
                chk("rd_no_stb", 32'(stb_cnt - stb0), 0);
            end else begin
                chk("wr_fack_out", 32'(s_fack_out), 1);
                chk("wr_fack_oe", 32'(s_fack_oe), 1);
                chk("wr_stb_count", 32'(stb_cnt - stb0), 1);
                chk("wr_idx", 32'(stb_idx), 32'(idx));
                model[idx] = wd;
            end
        end else begin
            chk("nomatch_oe", 32'(s_any_oe), 0);
            chk("nomatch_stb", 32'(stb_cnt - stb0), 0);
        end
        chk("busy_before_last", 32'(s_busy_pre), 1);
        chk("busy_after", 32'(BUSY), 0);
    endtask

    initial begin
        int stb0;
        int n;
        logic [DATA_W-1:0] keep;
        logic [ADDR_W-1:0] a;

        RST = 1'b1; SCLK = 1'b0; RX = 1'b1;
        LD_EN = 1'b0; LD_IDX = '0; LD_DATA = '0;
        for (int i = 0; i < 4; i++) model[i] = '0;
        tick(3);
        chk("rst_out", 32'(OUT), 0);
        chk("rst_oe", 32'(OUT_EN), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_stb", 32'(WR_STB), 0);
        chk("rst_wr_idx", 32'(WR_IDX), 0);
        RST = 1'b0;
        tick(2);

        // Preload then read.
        load(2, 8'h5D);
        run_frame(8'h1A, 1'b1, 8'h00);

        // Write then read back.
        run_frame(8'h1B, 1'b0, 8'h3F);
        run_frame(8'h1B, 1'b1, 8'h00);

        // Foreign address, then a frame to this device right after.
        run_frame(8'h2A, 1'b0, 8'h77);
        run_frame(8'h18, 1'b1, 8'h00);

        // Stalled write: SCLK stops low after four data bits.
        keep = model[1];
        stb0 = stb_cnt;
        frame(8'h19, 1'b0, 8'hA5, 4, -1, 1'b0);
        n = 0;
        while (BUSY && n < TO_CYC + 50) begin
            tick(1);
            n++;
        end
        // Last pin edge is consumed 3 CLKs later, then TO_CYC idle CLKs elapse.
        chk("timeout_cycles", 32'(n), 32'(TO_CYC + 3));
        chk("timeout_no_stb", 32'(stb_cnt - stb0), 0);
        run_frame(8'h19, 1'b1, 8'h00);
        chk("timeout_reg_kept", 32'(model[1]), 32'(keep));

        // Preload colliding with a bus commit to the same index.
        LD_IDX  = 2'd0;
        LD_DATA = 8'h41;
        stb0 = stb_cnt;
        frame(8'h18, 1'b0, 8'h6C, DATA_W, -1, 1'b1);
        chk("collide_stb", 32'(stb_cnt - stb0), 1);
        model[0] = 8'h41;
        run_frame(8'h18, 1'b1, 8'h00);

        // Randomised traffic.
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 3) == 0) load(int'($urandom_range(0, 3)), DATA_W'($urandom));
            if ($urandom_range(0, 3) != 0) a = ADDR_W'(8'h18 + $urandom_range(0, 3));
            else                            a = ADDR_W'($urandom);
            run_frame(a, 1'($urandom_range(0, 1)), DATA_W'($urandom));
        end

        // Reset in the middle of a read.
        load(3, 8'h96);
        frame(8'h1B, 1'b1, 8'h00, DATA_W, 3, 1'b0);
        for (int i = 0; i < 4; i++) model[i] = '0;
        RX = 1'b1;
        tick(4);
        for (int i = 0; i < 4; i++) run_frame(ADDR_W'(8'h18 + i), 1'b1, 8'h00);

        chk("wired_or_safe", 32'(oe_viol), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
